// File: rtl/cpu_bus_arbiter.sv
// Arbitrates CHANNELS CPU requestors onto one single-port memory bus with wait states,
// fixed or round-robin priority, an optional bus timeout and per-channel pipeline stalls.
module cpu_bus_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNELS      = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 16,
  localparam int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              request_valid,
  input  logic [CHANNELS-1:0]              request_write,
  input  logic [CHANNELS*ADDR_WIDTH-1:0]   request_address,
  input  logic [CHANNELS*SELECT_WIDTH-1:0] request_select,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   request_write_data,
  output logic [CHANNELS-1:0]              response_ready,
  output logic [CHANNELS-1:0]              response_error,
  output logic [DATA_WIDTH-1:0]            response_read_data,
  output logic [CHANNELS-1:0]              stall_request,
  output logic                             bus_valid,
  output logic                             bus_write,
  output logic [ADDR_WIDTH-1:0]            bus_address,
  output logic [SELECT_WIDTH-1:0]          bus_select,
  output logic [DATA_WIDTH-1:0]            bus_write_data,
  input  logic                             bus_ready,
  input  logic [DATA_WIDTH-1:0]            bus_read_data
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      grant_sel;
  logic [IDX_W-1:0]      rr_ptr;
  logic [TMR_W-1:0]      timer;
  logic [TMR_W-1:0]      timer_inc;
  logic                  timeout_hit;
  logic                  err_flag;
  logic [DATA_WIDTH-1:0] resp_data;

  function automatic logic [IDX_W-1:0] pick_fixed(input logic [CHANNELS-1:0] v);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) w = IDX_W'(i);
    end
    return w;
  endfunction

  // First requester at or after the pointer, wrapping modulo CHANNELS.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [CHANNELS-1:0] v,
                                               input logic [IDX_W-1:0]    p);
    logic [IDX_W-1:0] w;
    logic             found;
    int               c;
    w     = '0;
    found = 1'b0;
    for (int o = 0; o < CHANNELS; o++) begin
      c = (int'(p) + o) % CHANNELS;
      if (!found && v[c]) begin
        w     = IDX_W'(c);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    if (PRIORITY_MODE == 1) grant_sel = pick_rr(request_valid, rr_ptr);
    else                    grant_sel = pick_fixed(request_valid);
  end

  assign timer_inc   = timer + TMR_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (timer_inc == TIMEOUT_V);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|request_valid) state_next = ACCESS;
      ACCESS:  if (bus_ready || timeout_hit) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant stage: latch the winner's fields; access stage: capture data or time out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant          <= '0;
      rr_ptr         <= '0;
      timer          <= '0;
      err_flag       <= 1'b0;
      bus_write      <= 1'b0;
      bus_address    <= '0;
      bus_select     <= '0;
      bus_write_data <= '0;
      resp_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|request_valid) begin
            grant          <= grant_sel;
            rr_ptr         <= (grant_sel == LAST_IDX) ? '0 : grant_sel + IDX_W'(1);
            timer          <= '0;
            err_flag       <= 1'b0;
            bus_write      <= request_write[grant_sel];
            bus_address    <= request_address[grant_sel*ADDR_WIDTH +: ADDR_WIDTH];
            bus_select     <= request_select[grant_sel*SELECT_WIDTH +: SELECT_WIDTH];
            bus_write_data <= request_write_data[grant_sel*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ACCESS: begin
          if (bus_ready) begin
            resp_data <= bus_write ? '0 : bus_read_data;
            err_flag  <= 1'b0;
          end else begin
            timer <= timer_inc;
            if (timeout_hit) begin
              err_flag  <= 1'b1;
              resp_data <= '0;
            end
          end
        end
        RESPOND: err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  // Response stage: pulses decoded from the registered state and grant.
  always_comb begin
    bus_valid      = (state == ACCESS);
    response_ready = '0;
    response_error = '0;
    if (state == RESPOND) begin
      response_ready[grant] = 1'b1;
      response_error[grant] = err_flag;
    end
  end

  assign response_read_data = resp_data;
  assign stall_request      = request_valid & ~response_ready;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: a fixed-priority and a round-robin instance share all stimulus
// and are checked against directed expectations and a transaction-level reference model.
module tb_cpu_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0]    req_valid, req_write;
  logic [CH*AW-1:0] req_addr;
  logic [CH*SW-1:0] req_sel;
  logic [CH*DW-1:0] req_wdata;
  logic             bus_ready;
  logic [DW-1:0]    bus_rdata;

  logic [1:0][CH-1:0] resp_ready, resp_error, stall;
  logic [1:0][DW-1:0] resp_rdata, bus_wdata;
  logic [1:0]         bus_valid, bus_write;
  logic [1:0][AW-1:0] bus_addr;
  logic [1:0][SW-1:0] bus_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  cpu_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH), .PRIORITY_MODE(0), .TIMEOUT(TO)) u_fix (
    .clock(clock), .reset(rst_n), .request_valid(req_valid), .request_write(req_write),
    .request_address(req_addr), .request_select(req_sel), .request_write_data(req_wdata),
    .response_ready(resp_ready[0]), .response_error(resp_error[0]), .response_read_data(resp_rdata[0]),
    .stall_request(stall[0]), .bus_valid(bus_valid[0]), .bus_write(bus_write[0]),
    .bus_address(bus_addr[0]), .bus_select(bus_sel[0]), .bus_write_data(bus_wdata[0]),
    .bus_ready(bus_ready), .bus_read_data(bus_rdata));

  cpu_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH), .PRIORITY_MODE(1), .TIMEOUT(TO)) u_rr (
    .clock(clock), .reset(rst_n), .request_valid(req_valid), .request_write(req_write),
    .request_address(req_addr), .request_select(req_sel), .request_write_data(req_wdata),
    .response_ready(resp_ready[1]), .response_error(resp_error[1]), .response_read_data(resp_rdata[1]),
    .stall_request(stall[1]), .bus_valid(bus_valid[1]), .bus_write(bus_write[1]),
    .bus_address(bus_addr[1]), .bus_select(bus_sel[1]), .bus_write_data(bus_wdata[1]),
    .bus_ready(bus_ready), .bus_read_data(bus_rdata));

  // Reference model, one per instance (index = priority mode).
  bit            m_busy [2];
  bit            m_resp [2];
  bit            m_err  [2];
  int            m_wait [2];
  int            m_grant[2];
  int            m_ptr  [2];
  logic [DW-1:0] m_rdata[2];
  logic [AW-1:0] m_addr [2];
  logic          m_write[2];
  logic [SW-1:0] m_sel  [2];
  logic [DW-1:0] m_wdata[2];

  always @(posedge clock or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_busy[m] = 0; m_resp[m] = 0; m_err[m] = 0; m_wait[m] = 0;
        m_grant[m] = 0; m_ptr[m] = 0; m_rdata[m] = '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (m_resp[m]) begin
          m_resp[m] = 0;
        end else if (m_busy[m]) begin
          m_wait[m] = m_wait[m] + 1;
          if (bus_ready) begin
            m_busy[m] = 0; m_resp[m] = 1; m_err[m] = 0;
            m_rdata[m] = m_write[m] ? '0 : bus_rdata;
          end else if (m_wait[m] == TO) begin
            m_busy[m] = 0; m_resp[m] = 1; m_err[m] = 1; m_rdata[m] = '0;
          end
        end else if (req_valid != '0) begin
          w = -1;
          for (int k = 0; k < CH; k++) begin
            int c;
            c = (m == 1) ? (m_ptr[m] + k) % CH : k;
            if (w < 0 && req_valid[c]) w = c;
          end
          m_grant[m] = w;
          m_ptr[m]   = (w + 1) % CH;
          m_busy[m]  = 1;
          m_wait[m]  = 0;
          m_addr[m]  = req_addr[w*AW +: AW];
          m_write[m] = req_write[w];
          m_sel[m]   = req_sel[w*SW +: SW];
          m_wdata[m] = req_wdata[w*DW +: DW];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_sel = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b0) begin n_bad++; $display("FAIL reset_bus_valid[%0d]: got %b want 0", m, bus_valid[m]); end
      n_cmp++; if (resp_ready[m] !== 2'b00) begin n_bad++; $display("FAIL reset_resp_ready[%0d]: got %b want 00", m, resp_ready[m]); end
      n_cmp++; if (resp_error[m] !== 2'b00) begin n_bad++; $display("FAIL reset_resp_error[%0d]: got %b want 00", m, resp_error[m]); end
      n_cmp++; if (resp_rdata[m] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", m, resp_rdata[m]); end
      n_cmp++; if (bus_addr[m] !== 32'h0 || bus_write[m] !== 1'b0 || bus_sel[m] !== 4'h0 || bus_wdata[m] !== 32'h0) begin
        n_bad++; $display("FAIL reset_bus_fields[%0d]: got a=%h w=%b s=%h d=%h want zeros", m, bus_addr[m], bus_write[m], bus_sel[m], bus_wdata[m]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b0) begin n_bad++; $display("FAIL reset_idle_bus_valid[%0d]: got %b want 0", m, bus_valid[m]); end
    end
  endtask

  task automatic test_single_read();
    req_addr[AW +: AW] = 32'h0000_0010; req_write = 2'b00; req_valid = 2'b10;
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (stall[m] !== 2'b10) begin n_bad++; $display("FAIL single_stall_pre[%0d]: got %b want 10", m, stall[m]); end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b1) begin n_bad++; $display("FAIL single_bus_valid[%0d]: got %b want 1", m, bus_valid[m]); end
      n_cmp++; if (bus_addr[m] !== 32'h10) begin n_bad++; $display("FAIL single_bus_addr[%0d]: got %h want 10", m, bus_addr[m]); end
      n_cmp++; if (resp_ready[m] !== 2'b00) begin n_bad++; $display("FAIL single_early_ready[%0d]: got %b want 00", m, resp_ready[m]); end
      n_cmp++; if (stall[m] !== 2'b10) begin n_bad++; $display("FAIL single_stall[%0d]: got %b want 10", m, stall[m]); end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b10) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want 10", m, resp_ready[m]); end
      n_cmp++; if (resp_rdata[m] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rdata[%0d]: got %h want deadbeef", m, resp_rdata[m]); end
      n_cmp++; if (resp_error[m] !== 2'b00) begin n_bad++; $display("FAIL single_error[%0d]: got %b want 00", m, resp_error[m]); end
      n_cmp++; if (stall[m] !== 2'b00 || bus_valid[m] !== 1'b0) begin
        n_bad++; $display("FAIL single_resp_cycle[%0d]: got stall=%b bv=%b want 00/0", m, stall[m], bus_valid[m]);
      end
    end
    req_valid = 2'b00;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b00 || bus_valid[m] !== 1'b0) begin
        n_bad++; $display("FAIL single_after[%0d]: got ready=%b bv=%b want 00/0", m, resp_ready[m], bus_valid[m]);
      end
    end
  endtask

  task automatic test_timeout();
    req_addr[0 +: AW] = 32'h0000_0040; req_write = 2'b00; req_valid = 2'b01;
    bus_ready = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    for (int t = 1; t <= 4; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (bus_valid[m] !== 1'b1 || resp_ready[m] !== 2'b00) begin
          n_bad++; $display("FAIL timeout_wait[%0d] t=%0d: got bv=%b ready=%b want 1/00", m, t, bus_valid[m], resp_ready[m]);
        end
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b01) begin n_bad++; $display("FAIL timeout_ready[%0d]: got %b want 01", m, resp_ready[m]); end
      n_cmp++; if (resp_error[m] !== 2'b01) begin n_bad++; $display("FAIL timeout_error[%0d]: got %b want 01", m, resp_error[m]); end
      n_cmp++; if (resp_rdata[m] !== 32'h0) begin n_bad++; $display("FAIL timeout_rdata[%0d]: got %h want 0", m, resp_rdata[m]); end
    end
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01; bus_ready = 1'b1; bus_rdata = 32'h0BAD_CAFE;
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b01 || resp_error[m] !== 2'b00) begin
        n_bad++; $display("FAIL timeout_next[%0d]: got ready=%b err=%b want 01/00", m, resp_ready[m], resp_error[m]);
      end
      n_cmp++; if (resp_rdata[m] !== 32'h0BAD_CAFE) begin n_bad++; $display("FAIL timeout_next_rdata[%0d]: got %h want 0badcafe", m, resp_rdata[m]); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_write_wait();
    req_addr[AW +: AW] = 32'h0000_0020; req_write = 2'b10; req_sel[SW +: SW] = 4'b0011;
    req_wdata[DW +: DW] = 32'h1234_5678; req_valid = 2'b10;
    bus_ready = 1'b0; bus_rdata = 32'hCAFE_F00D;
    for (int t = 1; t <= 4; t++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        n_cmp++; if (bus_valid[m] !== 1'b1 || bus_write[m] !== 1'b1 || bus_sel[m] !== 4'b0011 ||
                     bus_wdata[m] !== 32'h1234_5678 || bus_addr[m] !== 32'h20) begin
          n_bad++; $display("FAIL write_fields[%0d] t=%0d: got bv=%b w=%b s=%b d=%h a=%h want 1/1/0011/12345678/20",
                            m, t, bus_valid[m], bus_write[m], bus_sel[m], bus_wdata[m], bus_addr[m]);
        end
        n_cmp++; if (resp_ready[m] !== 2'b00) begin n_bad++; $display("FAIL write_early[%0d] t=%0d: got %b want 00", m, t, resp_ready[m]); end
      end
    end
    bus_ready = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b10 || resp_error[m] !== 2'b00) begin
        n_bad++; $display("FAIL write_resp[%0d]: got ready=%b err=%b want 10/00", m, resp_ready[m], resp_error[m]);
      end
      n_cmp++; if (resp_rdata[m] !== 32'h0) begin n_bad++; $display("FAIL write_rdata[%0d]: got %h want 0", m, resp_rdata[m]); end
    end
    req_valid = 2'b00; req_write = 2'b00;
    tick();
  endtask

  task automatic test_contention();
    logic [CH-1:0] want;
    req_addr[0 +: AW] = 32'h0000_0100; req_addr[AW +: AW] = 32'h0000_0200;
    req_write = 2'b00; req_valid = 2'b11; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
    for (int t = 1; t <= 12; t++) begin
      tick();
      want = (t % 3 == 2) ? 2'b01 : 2'b00;
      n_cmp++; if (resp_ready[0] !== want) begin n_bad++; $display("FAIL fixed_grant t=%0d: got %b want %b", t, resp_ready[0], want); end
      want = (t % 3 != 2) ? 2'b00 : (((t / 3) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++; if (resp_ready[1] !== want) begin n_bad++; $display("FAIL rr_grant t=%0d: got %b want %b", t, resp_ready[1], want); end
    end
    req_valid = 2'b00;
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    req_addr[0 +: AW] = 32'h0000_0080; req_addr[AW +: AW] = 32'h0000_0200;
    req_write = 2'b00; req_valid = 2'b01; bus_ready = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre[%0d]: got %b want 1", m, bus_valid[m]); end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b0 || resp_ready[m] !== 2'b00) begin
        n_bad++; $display("FAIL rstmid_drop[%0d]: got bv=%b ready=%b want 0/00", m, bus_valid[m], resp_ready[m]);
      end
    end
    req_valid = 2'b11;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b0 || resp_ready[m] !== 2'b00) begin
        n_bad++; $display("FAIL rstmid_hold[%0d]: got bv=%b ready=%b want 0/00", m, bus_valid[m], resp_ready[m]);
      end
    end
    #2 rst_n = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (bus_valid[m] !== 1'b1 || bus_addr[m] !== 32'h80) begin
        n_bad++; $display("FAIL rstmid_restart[%0d]: got bv=%b a=%h want 1/80", m, bus_valid[m], bus_addr[m]);
      end
    end
    bus_ready = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      n_cmp++; if (resp_ready[m] !== 2'b01) begin n_bad++; $display("FAIL rstmid_resp[%0d]: got %b want 01", m, resp_ready[m]); end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [CH-1:0] er, ee;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = CH'($urandom);
      req_write = CH'($urandom);
      req_addr  = {$urandom, $urandom};
      req_sel   = SW*CH'($urandom);
      req_wdata = {$urandom, $urandom};
      bus_rdata = $urandom;
      bus_ready = (cyc < 300) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
      tick();
      for (int m = 0; m < 2; m++) begin
        er = '0; ee = '0;
        if (m_resp[m]) begin er[m_grant[m]] = 1'b1; ee[m_grant[m]] = m_err[m]; end
        n_cmp++; if (resp_ready[m] !== er) begin n_bad++; $display("FAIL rand_ready[%0d] cyc=%0d: got %b want %b", m, cyc, resp_ready[m], er); end
        n_cmp++; if (resp_error[m] !== ee) begin n_bad++; $display("FAIL rand_error[%0d] cyc=%0d: got %b want %b", m, cyc, resp_error[m], ee); end
        n_cmp++; if (bus_valid[m] !== m_busy[m]) begin n_bad++; $display("FAIL rand_bus_valid[%0d] cyc=%0d: got %b want %b", m, cyc, bus_valid[m], m_busy[m]); end
        n_cmp++; if (stall[m] !== (req_valid & ~er)) begin n_bad++; $display("FAIL rand_stall[%0d] cyc=%0d: got %b want %b", m, cyc, stall[m], req_valid & ~er); end
        if (m_resp[m]) begin
          n_cmp++; if (resp_rdata[m] !== m_rdata[m]) begin n_bad++; $display("FAIL rand_rdata[%0d] cyc=%0d: got %h want %h", m, cyc, resp_rdata[m], m_rdata[m]); end
        end
        if (m_busy[m]) begin
          n_cmp++; if (bus_addr[m] !== m_addr[m] || bus_write[m] !== m_write[m] || bus_sel[m] !== m_sel[m] || bus_wdata[m] !== m_wdata[m]) begin
            n_bad++; $display("FAIL rand_bus_fields[%0d] cyc=%0d: got a=%h w=%b s=%h d=%h want a=%h w=%b s=%h d=%h", m, cyc,
                              bus_addr[m], bus_write[m], bus_sel[m], bus_wdata[m], m_addr[m], m_write[m], m_sel[m], m_wdata[m]);
          end
        end
      end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_timeout();
    test_write_wait();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Parametrised arbiter that merges CHANNELS CPU memory requestors onto one shared single-port memory bus with variable wait states.
- Channel 0 is normally instruction fetch; channel 1 is the mem-stage data access; higher channels are spare.
- Generates per-channel stall_request outputs for the pipeline control block.
- Successor to separate fixed-latency rom/ram ports: adds contention, wait-state handshake, selectable priority mode and a bus timeout.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; multiple of 8; SELECT_WIDTH = DATA_WIDTH/8.
- CHANNELS, 2, number of requestors; range 1..8.
- PRIORITY_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 16, maximum ACCESS cycles without bus_ready before an error response; 0 disables the timeout.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- request_valid  input  CHANNELS  per-channel request; held with its fields stable until that channel's response_ready.
- request_write  input  CHANNELS  1 = write, 0 = read.
- request_address  input  CHANNELS*ADDR_WIDTH  packed; channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- request_select  input  CHANNELS*SELECT_WIDTH  packed byte enables.
- request_write_data  input  CHANNELS*DATA_WIDTH  packed write data.
- response_ready  output  CHANNELS  one-cycle completion pulse to the granted channel.
- response_error  output  CHANNELS  one-cycle pulse, coincident with response_ready, on timeout.
- response_read_data  output  DATA_WIDTH  read data; valid while response_ready is high.
- stall_request  output  CHANNELS  request_valid[i] & ~response_ready[i]; combinational.
- bus_valid  output  1  bus access in progress.
- bus_write  output  1  registered copy of the granted request_write.
- bus_address  output  ADDR_WIDTH  registered copy of the granted address.
- bus_select  output  SELECT_WIDTH  registered copy of the granted byte enables.
- bus_write_data  output  DATA_WIDTH  registered copy of the granted write data.
- bus_ready  input  1  memory completes the access this cycle.
- bus_read_data  input  DATA_WIDTH  sampled when bus_valid & bus_ready.

Behaviour:
- Reset state (reset low, asynchronous):
  - FSM in IDLE; all outputs 0; grant index 0; round-robin pointer 0; timer 0.
  - Reset asserted mid-access drops bus_valid immediately. The in-flight access is abandoned and no response is issued.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - If any request_valid is high, choose a winner, latch its index and fields into the bus registers, clear the timer, and go to ACCESS.
  - Otherwise stay in IDLE.
- Winner selection:
  - Mode 0: lowest set index.
  - Mode 1: first set index at or after the pointer, searching modulo CHANNELS. After a grant to channel i, pointer becomes (i+1) mod CHANNELS.
- ACCESS:
  - bus_valid=1 and the bus fields are constant throughout.
  - On bus_ready: capture bus_read_data (reads only; writes capture 0) and go to RESPOND.
  - Otherwise increment the timer. When the timer equals TIMEOUT (TIMEOUT≠0), set an error flag, force read data to 0, and go to RESPOND.
  - If bus_ready and the timeout coincide, bus_ready wins and no error is reported.
- RESPOND:
  - bus_valid=0; response_ready[grant]=1; response_error[grant]=error flag.
  - Next state is IDLE; the error flag clears.
- Requestor protocol:
  - The requestor must drop or replace its request in the cycle after response_ready.
  - Because RESPOND→IDLE adds one cycle, a still-high valid is not re-granted in the response cycle.
- Latency:
  - Valid sampled at edge k → bus_valid at k+1.
  - With zero wait states, response_ready at k+2 and IDLE at k+3. Minimum spacing between grants is 3 cycles.
  - Each wait state adds one cycle.
- If a requestor drops valid mid-ACCESS, the access still completes and the response pulse is still issued.
- Read data and response outputs are registered. stall_request is the only combinational output.

Test Plan:
- Single read, zero wait states:
  - Stimulus: ch1 valid, address 0x00000010, bus_ready=1 every cycle, bus_read_data=0xDEADBEEF.
  - Required: bus_valid one cycle later; response_ready=2'b10 and response_read_data=0xDEADBEEF exactly 2 cycles after valid; stall_request[1] high until then.
- Fixed-priority contention:
  - Stimulus: PRIORITY_MODE=0; ch0 and ch1 valid together and held high.
  - Required: ch0 granted first and every time thereafter; ch1 never granted while ch0 is held.
- Round-robin:
  - Stimulus: PRIORITY_MODE=1; both channels held valid.
  - Required: grants alternate 0,1,0,1, with response_ready spaced 3 cycles apart.
- Write with wait states:
  - Stimulus: ch1 write, select 4'b0011, data 0x12345678; bus_ready asserted on the 4th ACCESS cycle.
  - Required: bus fields stable for 4 cycles; response_ready 5 cycles after valid; response_read_data=0.
- Timeout:
  - Stimulus: TIMEOUT=4; bus_ready held 0.
  - Required: response_ready and response_error pulse together for the granted channel after 4 ACCESS cycles; response_read_data=0; next request proceeds normally.
- Reset mid-access:
  - Stimulus: assert reset low during ACCESS, between clock edges.
  - Required: bus_valid falls immediately; no response_ready; after release, pointer=0 and the FSM restarts from IDLE.
